// File: rtl/regfile_wb_arbiter.sv
// Purpose: merges ALU and buffered mul/div writebacks onto the single register file write port, with a pending-destination scoreboard.
// Latency: an ALU request appears on Regwr one cycle later; a mul/div result pops at the edge after its push at the earliest.
// Backpressure: md_ready = !full; after STARVE_MAX lost cycles alu_stall forces one FIFO pop, and an ALU write during that cycle is dropped.
module regfile_wb_arbiter #(
    parameter int MD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we,
    input  logic [4:0]  alu_waddr,
    input  logic [31:0] alu_wdata,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_waddr,
    input  logic [31:0] md_wdata,
    output logic        Regwr,
    output logic [4:0]  w_Reg,
    output logic [31:0] w_data,
    output logic [31:0] pending,
    output logic        alu_stall,
    output logic        err
);

    localparam int AW = $clog2(MD_DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } md_ent_t;

    md_ent_t        mem_q [MD_DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  starve_q, starve_d;
    logic           stall_q, stall_d;
    logic           regwr_q, regwr_d;
    logic [4:0]     w_reg_q, w_reg_d;
    logic [31:0]    w_data_q, w_data_d;
    logic [31:0]    pending_q, pending_d;
    logic           err_q, err_d;

    logic           empty, full;
    logic           push_store, alu_win, pop;
    md_ent_t        head;

    // The extra pointer MSB tells full from empty when the indices match.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign md_ready   = !full;
    // A result for r0 completes its handshake but occupies no slot.
    assign push_store = md_valid && !full && (md_waddr != 5'd0);
    // During the stall cycle the ALU can never win, so a non-empty FIFO pops.
    assign alu_win    = !stall_q && alu_we && (alu_waddr != 5'd0);
    assign pop        = !alu_win && !empty;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    assign Regwr      = regwr_q;
    assign w_Reg      = w_reg_q;
    assign w_data     = w_data_q;
    assign pending    = pending_q;
    assign alu_stall  = stall_q;
    assign err        = err_q;

    // Result storage; contents are meaningless until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (push_store) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {md_waddr, md_wdata};
        end
    end

    // Next-state: pointers, write port, scoreboard, starvation and error tracking.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_store};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        regwr_d   = alu_win || pop;
        w_reg_d   = w_reg_q;
        w_data_d  = w_data_q;
        pending_d = pending_q;
        starve_d  = starve_q;
        stall_d   = 1'b0;

        if (alu_win) begin
            w_reg_d  = alu_waddr;
            w_data_d = alu_wdata;
        end else if (pop) begin
            w_reg_d  = head.addr;
            w_data_d = head.data;
        end

        // Clear first so that a same-cycle issue to the same register wins.
        if (pop) begin
            pending_d[head.addr] = 1'b0;
        end
        if (md_issue && (md_issue_rd != 5'd0)) begin
            pending_d[md_issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        // Non-empty and not popping means the ALU took the port this cycle.
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q == CW'(STARVE_MAX - 1)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = starve_q + 1'b1;
        end

        err_d = err_q
              | (stall_q && alu_we)
              | (alu_win && pending_q[alu_waddr])
              | (md_valid && full);
    end

    // State registers; reset discards queued results and any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            regwr_q   <= 1'b0;
            w_reg_q   <= 5'd0;
            w_data_q  <= 32'd0;
            pending_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            regwr_q   <= regwr_d;
            w_reg_q   <= w_reg_d;
            w_data_q  <= w_data_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed scenarios plus randomized traffic against a queue-based reference of the writeback arbiter.
// Latency: outputs are compared on the falling edge following each rising edge.
// Backpressure: md_valid is driven only while the reference FIFO has room, except in a short illegal window.
module tb_regfile_wb_arbiter;

    localparam int MD_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_waddr;
    logic [31:0] md_wdata;
    logic        Regwr;
    logic [4:0]  w_Reg;
    logic [31:0] w_data;
    logic [31:0] pending;
    logic        alu_stall;
    logic        err;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.MD_DEPTH(MD_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr), .md_wdata(md_wdata),
        .Regwr(Regwr), .w_Reg(w_Reg), .w_data(w_data),
        .pending(pending), .alu_stall(alu_stall), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of results, a per-register outstanding flag,
    // and a count of cycles the queue has waited while the ALU took the port.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    bit   [31:0] m_pending = '0;
    bit          m_err     = 1'b0;
    bit          m_stall   = 1'b0;
    bit          m_regwr   = 1'b0;
    logic [4:0]  m_wreg    = '0;
    logic [31:0] m_wdata   = '0;
    int          m_lost    = 0;
    bit          m_alu_ok, m_do_pop, m_was_full, m_was_empty;
    ent_t        m_h;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pending = '0; m_err = 0; m_stall = 0; m_regwr = 0;
            m_wreg = '0; m_wdata = '0; m_lost = 0;
        end else begin
            m_was_full  = (mq.size() == MD_DEPTH);
            m_was_empty = (mq.size() == 0);
            m_alu_ok    = !m_stall && alu_we && (alu_waddr != 0);
            m_do_pop    = !m_alu_ok && !m_was_empty;
            if ((m_stall && alu_we) || (m_alu_ok && m_pending[alu_waddr]) || (md_valid && m_was_full))
                m_err = 1;
            if (m_alu_ok) begin
                m_regwr = 1; m_wreg = alu_waddr; m_wdata = alu_wdata;
            end else if (m_do_pop) begin
                m_h = mq.pop_front();
                m_regwr = 1; m_wreg = m_h.a; m_wdata = m_h.d;
                m_pending[m_h.a] = 0;
            end else begin
                m_regwr = 0;
            end
            if (md_issue && md_issue_rd != 0) m_pending[md_issue_rd] = 1;
            if (md_valid && !m_was_full && md_waddr != 0) mq.push_back({md_waddr, md_wdata});
            if (m_was_empty || m_do_pop) begin
                m_lost = 0; m_stall = 0;
            end else begin
                m_lost++;
                if (m_lost == STARVE_MAX) begin m_lost = 0; m_stall = 1; end
                else m_stall = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alu_we = 0; alu_waddr = 0; alu_wdata = 0;
        md_issue = 0; md_issue_rd = 0;
        md_valid = 0; md_waddr = 0; md_wdata = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step(); step();
        checks++; if (Regwr !== 1'b0)    begin errors++; $display("FAIL reset_regwr: got %0b want 0", Regwr); end
        checks++; if (w_Reg !== 5'd0)    begin errors++; $display("FAIL reset_wreg: got %0d want 0", w_Reg); end
        checks++; if (w_data !== 32'd0)  begin errors++; $display("FAIL reset_wdata: got %h want 0", w_data); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h want 0", pending); end
        checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", alu_stall); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_mdready: got %0b want 1", md_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_alu_write();
        alu_we = 1; alu_waddr = 5; alu_wdata = 32'hDEADBEEF;
        step();
        idle();
        checks++; if (Regwr !== 1'b1) begin errors++; $display("FAIL alu_regwr: got %0b want 1", Regwr); end
        checks++; if (w_Reg !== 5'd5) begin errors++; $display("FAIL alu_wreg: got %0d want 5", w_Reg); end
        checks++; if (w_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata: got %h want deadbeef", w_data); end
        step();
        checks++; if (Regwr !== 1'b0) begin errors++; $display("FAIL alu_regwr_drop: got %0b want 0", Regwr); end
        checks++; if (w_Reg !== 5'd5) begin errors++; $display("FAIL alu_wreg_hold: got %0d want 5", w_Reg); end
    endtask

    task automatic test_scoreboard();
        md_issue = 1; md_issue_rd = 7;
        step();
        md_issue = 0;
        checks++; if (pending !== 32'h80) begin errors++; $display("FAIL sb_set: got %h want 00000080", pending); end
        md_valid = 1; md_waddr = 7; md_wdata = 32'h1234;
        step();
        md_valid = 0;
        checks++; if (Regwr !== 1'b0) begin errors++; $display("FAIL sb_nobypass: got %0b want 0", Regwr); end
        checks++; if (pending !== 32'h80) begin errors++; $display("FAIL sb_hold: got %h want 00000080", pending); end
        step();
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd7 || w_data !== 32'h1234)
            begin errors++; $display("FAIL sb_commit: got %0b/%0d/%h want 1/7/00001234", Regwr, w_Reg, w_data); end
        checks++; if (pending !== 32'h0) begin errors++; $display("FAIL sb_clear: got %h want 0", pending); end
        step();
    endtask

    task automatic test_full_starve();
        int k;
        alu_we = 1; alu_waddr = 1; alu_wdata = 32'hA0;
        md_valid = 1; md_waddr = 10; md_wdata = 32'h100;
        step();
        md_waddr = 11; md_wdata = 32'h101; alu_wdata = 32'hA1;
        step();
        md_valid = 0;
        checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", md_ready); end
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd1) begin errors++; $display("FAIL full_aluwins: got %0b/%0d want 1/1", Regwr, w_Reg); end
        k = 0;
        while (alu_stall !== 1'b1 && k < 10) begin step(); k++; end
        checks++; if (k != 3) begin errors++; $display("FAIL starve_cycles: got %0d want 3", k); end
        alu_we = 0;
        step();
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd10 || w_data !== 32'h100)
            begin errors++; $display("FAIL starve_pop: got %0b/%0d/%h want 1/10/00000100", Regwr, w_Reg, w_data); end
        checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL starve_pulse: got %0b want 0", alu_stall); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL starve_err: got %0b want 0", err); end
        checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %0b want 1", md_ready); end
        alu_we = 1; md_valid = 1; md_waddr = 12; md_wdata = 32'h102;
        step();
        idle();
        step();
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd11) begin errors++; $display("FAIL order_first: got %0b/%0d want 1/11", Regwr, w_Reg); end
        step();
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd12) begin errors++; $display("FAIL order_second: got %0b/%0d want 1/12", Regwr, w_Reg); end
        step();
        checks++; if (Regwr !== 1'b0) begin errors++; $display("FAIL drain_idle: got %0b want 0", Regwr); end
    endtask

    task automatic test_r0();
        alu_we = 1; alu_waddr = 0; alu_wdata = 32'h5555;
        step();
        idle();
        checks++; if (Regwr !== 1'b0) begin errors++; $display("FAIL r0_alu: got %0b want 0", Regwr); end
        md_valid = 1; md_waddr = 0; md_wdata = 32'h6666;
        step();
        md_valid = 0;
        checks++; if (Regwr !== 1'b0 || md_ready !== 1'b1 || pending !== 32'h0)
            begin errors++; $display("FAIL r0_push: got %0b/%0b/%h want 0/1/0", Regwr, md_ready, pending); end
        step();
        checks++; if (Regwr !== 1'b0) begin errors++; $display("FAIL r0_nostore: got %0b want 0", Regwr); end
    endtask

    task automatic test_collision();
        md_issue = 1; md_issue_rd = 3;
        md_valid = 1; md_waddr = 3; md_wdata = 32'h333;
        step();
        md_valid = 0;
        step();
        md_issue = 0;
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd3 || w_data !== 32'h333)
            begin errors++; $display("FAIL coll_commit: got %0b/%0d/%h want 1/3/00000333", Regwr, w_Reg, w_data); end
        checks++; if (pending !== 32'h8) begin errors++; $display("FAIL coll_setwins: got %h want 00000008", pending); end
    endtask

    task automatic test_error_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clean: got %0b want 0", err); end
        md_issue = 1; md_issue_rd = 9;
        step();
        md_issue = 0;
        alu_we = 1; alu_waddr = 9; alu_wdata = 32'h99;
        step();
        alu_we = 0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_waw: got %0b want 1", err); end
        checks++; if (Regwr !== 1'b1 || w_Reg !== 5'd9) begin errors++; $display("FAIL err_waw_write: got %0b/%0d want 1/9", Regwr, w_Reg); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", err); end
        alu_we = 1; alu_waddr = 4; alu_wdata = 32'h44;
        md_issue = 1; md_issue_rd = 5;
        md_valid = 1; md_waddr = 6; md_wdata = 32'h66;
        step();
        idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (Regwr !== 1'b0 || w_Reg !== 5'd0 || w_data !== 32'd0)
            begin errors++; $display("FAIL arst_write: got %0b/%0d/%h want 0/0/0", Regwr, w_Reg, w_data); end
        checks++; if (pending !== 32'd0 || err !== 1'b0 || alu_stall !== 1'b0 || md_ready !== 1'b1)
            begin errors++; $display("FAIL arst_state: got %h/%0b/%0b/%0b want 0/0/0/1", pending, err, alu_stall, md_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (Regwr !== 1'b0) begin errors++; $display("FAIL arst_flushed: got %0b want 0", Regwr); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            checks++; if (Regwr !== m_regwr) begin errors++; $display("FAIL rand_regwr c%0d: got %0b want %0b", i, Regwr, m_regwr); end
            checks++; if (m_regwr && (w_Reg !== m_wreg || w_data !== m_wdata))
                begin errors++; $display("FAIL rand_wdat c%0d: got %0d/%h want %0d/%h", i, w_Reg, w_data, m_wreg, m_wdata); end
            checks++; if (pending !== m_pending) begin errors++; $display("FAIL rand_pending c%0d: got %h want %h", i, pending, m_pending); end
            checks++; if (alu_stall !== m_stall) begin errors++; $display("FAIL rand_stall c%0d: got %0b want %0b", i, alu_stall, m_stall); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err c%0d: got %0b want %0b", i, err, m_err); end
            checks++; if (md_ready !== (mq.size() < MD_DEPTH))
                begin errors++; $display("FAIL rand_ready c%0d: got %0b want %0b", i, md_ready, mq.size() < MD_DEPTH); end
            alu_we    = ($urandom_range(0, 9) < 7);
            alu_waddr = 5'($urandom_range(0, 31));
            if (m_pending[alu_waddr]) alu_waddr = 5'd0;
            if (m_stall && $urandom_range(0, 3) != 0) alu_we = 1'b0;
            alu_wdata   = $urandom;
            md_issue    = ($urandom_range(0, 3) == 0);
            md_issue_rd = 5'($urandom_range(0, 31));
            md_valid    = ($urandom_range(0, 1) == 1) && ((mq.size() < MD_DEPTH) || i > 560);
            md_waddr    = 5'($urandom_range(0, 31));
            md_wdata    = $urandom;
            step();
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alu_write();
        test_scoreboard();
        test_full_starve();
        test_r0();
        test_collision();
        test_error_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
